// File: rtl/cond_logic.sv
// Conditional-execution stage: architectural NZCV register, condition evaluation,
// and gating of PC/register/memory/flag write enables with the latched condition.
module cond_logic #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       CondExReg,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [1:0] r_flags_nz;
  logic [1:0] r_flags_cv;
  logic       r_condex;
  logic       w_n, w_z, w_c, w_v;
  logic       w_ge;
  logic       w_condex;
  logic       w_wr_nz, w_wr_cv;

  assign {w_n, w_z} = r_flags_nz;
  assign {w_c, w_v} = r_flags_cv;
  assign w_ge       = (w_n == w_v);

  always_comb begin
    w_condex = 1'b0;
    unique case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = w_ge;
      4'b1011: w_condex = ~w_ge;
      4'b1100: w_condex = ~w_z & w_ge;
      4'b1101: w_condex = w_z | ~w_ge;
      4'b1110: w_condex = 1'b1;
      4'b1111: w_condex = NV_EXECUTES;
      default: w_condex = 1'b0;
    endcase
  end

  // Flag writes use the pre-edge latched condition, so a same-edge CondLatch
  // never lets an instruction's own flag result decide whether it executes.
  assign w_wr_nz = FlagW[1] & r_condex;
  assign w_wr_cv = FlagW[0] & r_condex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags_nz <= RESET_FLAGS[3:2];
      r_flags_cv <= RESET_FLAGS[1:0];
      r_condex   <= 1'b0;
    end else begin
      if (w_wr_nz)   r_flags_nz <= ALUFlags[3:2];
      if (w_wr_cv)   r_flags_cv <= ALUFlags[1:0];
      if (CondLatch) r_condex   <= w_condex;
    end
  end

  assign Flags     = {r_flags_nz, r_flags_cv};
  assign CondEx    = w_condex;
  assign CondExReg = r_condex;
  assign PCWrite   = NextPC | (PCS & r_condex);
  assign RegWrite  = RegW & r_condex & ~NoWrite;
  assign MemWrite  = MemW & r_condex;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic; expected values are queued when stimulus is
// driven and popped when the matching output is sampled.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch, PCS, NextPC, RegW, MemW, NoWrite;
  logic [3:0] Flags, Flags0;
  logic       CondEx, CondExReg, PCWrite, RegWrite, MemWrite;
  logic       CondEx0, CondExReg0, PCWrite0, RegWrite0, MemWrite0;

  int checks   = 0;
  int failures = 0;
  logic [3:0] sb_q[$];

  cond_logic #(.RESET_FLAGS(4'b0000), .NV_EXECUTES(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .Flags(Flags), .CondEx(CondEx), .CondExReg(CondExReg),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
  );

  cond_logic #(.RESET_FLAGS(4'b0000), .NV_EXECUTES(1'b0)) dut_nv0 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .Flags(Flags0), .CondEx(CondEx0), .CondExReg(CondExReg0),
    .PCWrite(PCWrite0), .RegWrite(RegWrite0), .MemWrite(MemWrite0)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cc;           4'h3: return !cc;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cc && !z;     4'h9: return !cc || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return nv;
    endcase
  endfunction

  task automatic expect_val(input logic [3:0] e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %b but scoreboard empty", tag, obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_cond(input logic [3:0] c);
    Cond = c; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    latch_cond(4'b1110);
    ALUFlags = f; FlagW = 2'b11;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; CondLatch = 1'b0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    #2;
    expect_val(4'b0000); check("reset_flags", Flags);
    expect_val(4'b0);    check("reset_condexreg", {3'b0, CondExReg});
    expect_val(4'b0);    check("reset_regwrite", {3'b0, RegWrite});
    expect_val(4'b0);    check("reset_memwrite", {3'b0, MemWrite});
    PCS = 1'b1; NextPC = 1'b1; #1;
    expect_val(4'b1);    check("reset_pcwrite_nextpc", {3'b0, PCWrite});
    NextPC = 1'b0; #1;
    expect_val(4'b0);    check("reset_pcwrite_gated", {3'b0, PCWrite});
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Mid-cycle asynchronous reset with all flags set
    load_flags(4'b1111);
    expect_val(4'b1111); check("preload_flags", Flags);
    expect_val(4'b1);    check("preload_condexreg", {3'b0, CondExReg});
    RegW = 1'b1; #2;
    reset = 1'b1; #1;
    expect_val(4'b0000); check("midreset_flags", Flags);
    expect_val(4'b0);    check("midreset_condexreg", {3'b0, CondExReg});
    expect_val(4'b0);    check("midreset_regwrite", {3'b0, RegWrite});
    tick();
    reset = 1'b0; RegW = 1'b0;
    tick();

    // Full condition sweep, both NV_EXECUTES settings
    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0]; #1;
        expect_val({3'b0, ref_cond(c[3:0], f[3:0], 1'b1)});
        check($sformatf("condex_nv1_f%0h_c%0h", f, c), {3'b0, CondEx});
        expect_val({3'b0, ref_cond(c[3:0], f[3:0], 1'b0)});
        check($sformatf("condex_nv0_f%0h_c%0h", f, c), {3'b0, CondEx0});
      end
    end

    // Split half writes
    load_flags(4'b0000);
    ALUFlags = 4'b1111; FlagW = 2'b10; tick();
    expect_val(4'b1100); check("split_nz", Flags);
    FlagW = 2'b01; tick();
    expect_val(4'b1111); check("split_cv", Flags);
    ALUFlags = 4'b0000; FlagW = 2'b00; tick();
    expect_val(4'b1111); check("flagw00_hold", Flags);

    // Gated-off instruction
    load_flags(4'b0000);
    latch_cond(4'b0000);
    expect_val(4'b0); check("eq_false_latched", {3'b0, CondExReg});
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    expect_val(4'b0); check("gated_regwrite", {3'b0, RegWrite});
    expect_val(4'b0); check("gated_memwrite", {3'b0, MemWrite});
    expect_val(4'b0); check("gated_pcwrite", {3'b0, PCWrite});
    tick();
    expect_val(4'b0000); check("gated_flags_hold", Flags);
    NextPC = 1'b1; #1;
    expect_val(4'b1); check("nextpc_forces_pcwrite", {3'b0, PCWrite});
    NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00;

    // Compare-class instruction
    latch_cond(4'b1110);
    ALUFlags = 4'b0100; FlagW = 2'b11; RegW = 1'b1; NoWrite = 1'b1; MemW = 1'b1; PCS = 1'b1; #1;
    expect_val(4'b0); check("cmp_regwrite_blocked", {3'b0, RegWrite});
    expect_val(4'b1); check("cmp_memwrite", {3'b0, MemWrite});
    expect_val(4'b1); check("cmp_pcwrite", {3'b0, PCWrite});
    NoWrite = 1'b0; #1;
    expect_val(4'b1); check("regwrite_enabled", {3'b0, RegWrite});
    NoWrite = 1'b1;
    tick();
    FlagW = 2'b00; RegW = 1'b0; NoWrite = 1'b0; MemW = 1'b0; PCS = 1'b0;
    expect_val(4'b0100); check("cmp_flags", Flags);
    Cond = 4'b0000; #1;
    expect_val(4'b1); check("cmp_then_eq", {3'b0, CondEx});

    // Same-edge latch and flag write
    load_flags(4'b0000);
    Cond = 4'b0000; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    CondLatch = 1'b0; FlagW = 2'b00;
    expect_val(4'b0100); check("sameedge_flags", Flags);
    expect_val(4'b0);    check("sameedge_condexreg_old_z", {3'b0, CondExReg});

    if (sb_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
